// File: rtl/axi_buffer_rab_bram_mc.sv
// -----------------------------------------------------------------------------
// axi_buffer_rab_bram_mc
// Multi-channel first-word-fall-through FIFO. NUM_CH logical queues share one
// BRAM, and each channel owns a DEPTH_PER_CH slice at {ch, ptr}. Words read
// from the BRAM arrive one cycle later and land in a 2-entry skid FIFO, which
// drives the output. Channels are served round-robin.
//
// Ports
//   clk, rstn      clock; synchronous active-low reset
//   valid_in       upstream word valid
//   ch_in          target channel of data_in
//   data_in        upstream payload
//   ready_out      !full[ch_in] (combinational on ch_in)
//   valid_out      skid head valid
//   ch_out         channel of data_out
//   data_out       skid head payload
//   ready_in       downstream accept
//   flush_entries  per-channel synchronous flush
//   almost_full    per-channel, registered: count >= AFULL_THRESH
//   fill_level     per-channel BRAM word count, registered, packed by channel
//   parity_err     sticky parity error
//
// Build option
//   AXI_BUFFER_RAB_BRAM_MC_PARITY_EN: store an even-parity bit with each word
//   and check it as the word enters the skid stage. When the macro is not
//   defined, parity_err is tied low.
// -----------------------------------------------------------------------------
module axi_buffer_rab_bram_mc #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEPTH_PER_CH = 128,
  parameter int unsigned AFULL_THRESH = DEPTH_PER_CH - 1,
  localparam int unsigned CW = $clog2(NUM_CH),
  localparam int unsigned PW = $clog2(DEPTH_PER_CH),
  localparam int unsigned LW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_in,
  input  logic [CW-1:0]          ch_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   ready_out,
  output logic                   valid_out,
  output logic [CW-1:0]          ch_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  input  logic                   ready_in,
  input  logic [NUM_CH-1:0]      flush_entries,
  output logic [NUM_CH-1:0]      almost_full,
  output logic [NUM_CH*LW-1:0]   fill_level,
  output logic                   parity_err
);

`ifdef AXI_BUFFER_RAB_BRAM_MC_PARITY_EN
  localparam int unsigned BW = DATA_WIDTH + 1;
`else
  localparam int unsigned BW = DATA_WIDTH;
`endif

  // Per-channel queue state
  logic [PW-1:0]     wr_ptr  [NUM_CH];
  logic [PW-1:0]     rd_ptr  [NUM_CH];
  logic [LW-1:0]     count_q [NUM_CH];
  logic [LW-1:0]     count_d [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] afull_q;
  logic [NUM_CH-1:0] push_vec;
  logic [NUM_CH-1:0] iss_vec;
  logic              push;

  // Shared storage and read path
  logic [BW-1:0]     mem [NUM_CH*DEPTH_PER_CH];
  logic [BW-1:0]     wr_word;
  logic [BW-1:0]     rd_word_q;

  // Issue arbitration
  logic [CW-1:0]     rr_q;
  logic [CW-1:0]     sel;
  logic [CW-1:0]     idx;
  logic              found;
  logic              issue;
  logic [2:0]        occ;

  // In-flight read and skid FIFO (entry 0 is the head)
  logic              inflight_q;
  logic [CW-1:0]     inflight_ch_q;
  logic [1:0]        skid_cnt_q;
  logic [1:0]        skid_cnt_d;
  logic [DATA_WIDTH-1:0] skid_data_q [2];
  logic [DATA_WIDTH-1:0] skid_data_d [2];
  logic [CW-1:0]     skid_ch_q [2];
  logic [CW-1:0]     skid_ch_d [2];
  logic              pop;
  logic              keep0;
  logic              keep1;
  logic              app;

  // ---------------------------------------------------------------------------
  // Push side
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      full[c] = (count_q[c] == LW'(DEPTH_PER_CH));
    end
  end

  assign ready_out = !full[ch_in];
  // A flush of the target channel discards a push made in the same cycle.
  assign push      = valid_in && ready_out && !flush_entries[ch_in];

  always_comb begin
    push_vec = '0;
    if (push) push_vec[ch_in] = 1'b1;
  end

`ifdef AXI_BUFFER_RAB_BRAM_MC_PARITY_EN
  assign wr_word = {^data_in, data_in};
`else
  assign wr_word = data_in;
`endif

  // ---------------------------------------------------------------------------
  // Read issue: round-robin over channels with registered count > 0. A channel
  // that is pushed in this cycle only becomes eligible in the next one, so the
  // read and write addresses never collide.
  // ---------------------------------------------------------------------------
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = rr_q + CW'(k);
      if (!found && (count_q[idx] != '0) && !flush_entries[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign valid_out = (skid_cnt_q != 2'd0);
  assign pop       = valid_out && ready_in;

  // Skid occupancy after this cycle's pop, counting the word already in flight.
  assign occ   = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue = found && (occ < 3'd2);

  always_comb begin
    iss_vec = '0;
    if (issue) iss_vec[sel] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Per-channel pointers and counts. Flush has priority over push and issue.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign count_d[c] = count_q[c] + LW'(push_vec[c]) - LW'(iss_vec[c]);

    always_ff @(posedge clk) begin
      if (!rstn || flush_entries[c]) begin
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
        count_q[c] <= '0;
        afull_q[c] <= 1'b0;
      end else begin
        if (push_vec[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (iss_vec[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        count_q[c] <= count_d[c];
        afull_q[c] <= (count_d[c] >= LW'(AFULL_THRESH));
      end
    end

    assign fill_level[c*LW +: LW] = count_q[c];
  end

  assign almost_full = afull_q;

  // ---------------------------------------------------------------------------
  // Shared BRAM: one write port and one registered read port, no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push)  mem[{ch_in, wr_ptr[ch_in]}] <= wr_word;
    if (issue) rd_word_q <= mem[{sel, rd_ptr[sel]}];
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO next state: keep the surviving entries, which are those not popped
  // and not flushed, then append the returning word. The slots are repacked so
  // the head is always entry 0. The issue rule guarantees at most two survivors.
  // ---------------------------------------------------------------------------
  always_comb begin
    keep0 = (skid_cnt_q != 2'd0) && !pop && !flush_entries[skid_ch_q[0]];
    keep1 = (skid_cnt_q == 2'd2) && !flush_entries[skid_ch_q[1]];
    app   = inflight_q && !flush_entries[inflight_ch_q];

    skid_cnt_d     = 2'(keep0) + 2'(keep1) + 2'(app);
    skid_data_d[0] = '0;
    skid_data_d[1] = '0;
    skid_ch_d[0]   = '0;
    skid_ch_d[1]   = '0;

    if (keep0) begin
      skid_data_d[0] = skid_data_q[0];
      skid_ch_d[0]   = skid_ch_q[0];
      if (keep1) begin
        skid_data_d[1] = skid_data_q[1];
        skid_ch_d[1]   = skid_ch_q[1];
      end else if (app) begin
        skid_data_d[1] = rd_word_q[DATA_WIDTH-1:0];
        skid_ch_d[1]   = inflight_ch_q;
      end
    end else if (keep1) begin
      skid_data_d[0] = skid_data_q[1];
      skid_ch_d[0]   = skid_ch_q[1];
      if (app) begin
        skid_data_d[1] = rd_word_q[DATA_WIDTH-1:0];
        skid_ch_d[1]   = inflight_ch_q;
      end
    end else if (app) begin
      skid_data_d[0] = rd_word_q[DATA_WIDTH-1:0];
      skid_ch_d[0]   = inflight_ch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q           <= '0;
      inflight_q     <= 1'b0;
      inflight_ch_q  <= '0;
      skid_cnt_q     <= '0;
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_ch_q[0]   <= '0;
      skid_ch_q[1]   <= '0;
    end else begin
      if (issue) rr_q <= sel + 1'b1;
      inflight_q     <= issue;
      inflight_ch_q  <= sel;
      skid_cnt_q     <= skid_cnt_d;
      skid_data_q[0] <= skid_data_d[0];
      skid_data_q[1] <= skid_data_d[1];
      skid_ch_q[0]   <= skid_ch_d[0];
      skid_ch_q[1]   <= skid_ch_d[1];
    end
  end

  assign data_out = skid_data_q[0];
  assign ch_out   = skid_ch_q[0];

  // ---------------------------------------------------------------------------
  // Parity check on words entering the skid stage. Words that fail the check
  // are still delivered.
  // ---------------------------------------------------------------------------
`ifdef AXI_BUFFER_RAB_BRAM_MC_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perr_q <= 1'b0;
    end else if (app && (^rd_word_q)) begin
      perr_q <= 1'b1;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_buffer_rab_bram_mc.sv
module tb_axi_buffer_rab_bram_mc;
  localparam int DW  = 32;
  localparam int NC  = 4;
  localparam int DEP = 128;
  localparam int CW  = 2;
  localparam int LW  = 8;

`ifdef AXI_BUFFER_RAB_BRAM_MC_PARITY_EN
  localparam logic [31:0] PERR_EXP = 32'd1;
`else
  localparam logic [31:0] PERR_EXP = 32'd0;
`endif

  // check kinds
  localparam int K_VALID = 0, K_FILL = 1, K_AFULL = 2, K_READY = 3,
                 K_PERR = 4, K_DATA = 5, K_GEN = 6;
  // generic check ids
  localparam int G_DRAIN = 0, G_LAT = 1, G_BUB = 2;

  logic              clk;
  logic              rstn;
  logic              valid_in;
  logic [CW-1:0]     ch_in;
  logic [DW-1:0]     data_in;
  logic              ready_out;
  logic              valid_out;
  logic [CW-1:0]     ch_out;
  logic [DW-1:0]     data_out;
  logic              ready_in;
  logic [NC-1:0]     flush_entries;
  logic [NC-1:0]     almost_full;
  logic [NC*LW-1:0]  fill_level;
  logic              parity_err;

  axi_buffer_rab_bram_mc #(
    .DATA_WIDTH   (DW),
    .NUM_CH       (NC),
    .DEPTH_PER_CH (DEP)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .valid_in      (valid_in),
    .ch_in         (ch_in),
    .data_in       (data_in),
    .ready_out     (ready_out),
    .valid_out     (valid_out),
    .ch_out        (ch_out),
    .data_out      (data_out),
    .ready_in      (ready_in),
    .flush_entries (flush_entries),
    .almost_full   (almost_full),
    .fill_level    (fill_level),
    .parity_err    (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int          kind;
    int          ch;
    logic [31:0] expv;
    logic [31:0] act;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];

  int total = 0;
  int bad   = 0;

  function automatic string kname(int kind, int id);
    case (kind)
      K_VALID: return "valid_out";
      K_FILL:  return "fill_level";
      K_AFULL: return "almost_full";
      K_READY: return "ready_out";
      K_PERR:  return "parity_err";
      K_DATA:  return "data_out_hold";
      default: begin
        case (id)
          G_DRAIN: return "drain_left";
          G_LAT:   return "first_latency";
          default: return "bubbles";
        endcase
      end
    endcase
  endfunction

  // Monitor: pops the scoreboard on every output handshake, and evaluates
  // queued status checks against the DUT outputs.
  exp_t        e_m;
  chk_t        c_m;
  logic [31:0] act_m;

  always @(negedge clk) begin
    if (rstn && valid_out && ready_in) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: actual ch=%0d data=%h, required no word", ch_out, data_out);
      end else begin
        e_m = exp_q.pop_front();
        if (e_m.ch !== ch_out || e_m.data !== data_out) begin
          bad++;
          $display("FAIL out_word: actual ch=%0d data=%h, required ch=%0d data=%h",
                   ch_out, data_out, e_m.ch, e_m.data);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c_m = chk_q.pop_front();
      case (c_m.kind)
        K_VALID: act_m = 32'(valid_out);
        K_FILL:  act_m = 32'(fill_level[c_m.ch*LW +: LW]);
        K_AFULL: act_m = 32'(almost_full[c_m.ch]);
        K_READY: act_m = 32'(ready_out);
        K_PERR:  act_m = 32'(parity_err);
        K_DATA:  act_m = data_out;
        default: act_m = c_m.act;
      endcase
      total++;
      if (act_m !== c_m.expv) begin
        bad++;
        $display("FAIL %s ch%0d: actual=%0h required=%0h", kname(c_m.kind, c_m.ch), c_m.ch, act_m, c_m.expv);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input int ch, input logic [31:0] expv, input logic [31:0] act);
    chk_q.push_back('{kind, ch, expv, act});
  endtask

  task automatic push(input logic [CW-1:0] ch, input logic [DW-1:0] d);
    valid_in = 1'b1;
    ch_in    = ch;
    data_in  = d;
    exp_q.push_back('{ch, d});
    step();
    valid_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    ready_in = 1'b1;
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(K_GEN, G_DRAIN, 32'd0, 32'(exp_q.size()));
    step();
  endtask

  task automatic reset_checks(input int ch);
    ch_in = CW'(ch);
    chk(K_VALID, 0, 32'd0, 32'd0);
    chk(K_DATA, 0, 32'd0, 32'd0);
    chk(K_FILL, ch, 32'd0, 32'd0);
    chk(K_AFULL, ch, 32'd0, 32'd0);
    chk(K_READY, ch, 32'd1, 32'd0);
    chk(K_PERR, 0, 32'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int bub;

    rstn          = 1'b0;
    valid_in      = 1'b0;
    ch_in         = '0;
    data_in       = '0;
    ready_in      = 1'b0;
    flush_entries = '0;
    step();
    step();
    rstn = 1'b1;
    reset_checks(0);
    step();

    // Fill channel 0 with downstream stalled
    ready_in = 1'b0;
    for (int i = 0; i < 130; i++) begin
      push(2'd0, 32'h1000_0000 + 32'(i));
      if (i == 127) begin
        chk(K_FILL, 0, 32'd126, 32'd0);
        chk(K_AFULL, 0, 32'd0, 32'd0);
        chk(K_READY, 0, 32'd1, 32'd0);
      end
      if (i == 128) begin
        chk(K_FILL, 0, 32'd127, 32'd0);
        chk(K_AFULL, 0, 32'd1, 32'd0);
      end
      if (i == 129) begin
        chk(K_FILL, 0, 32'd128, 32'd0);
        chk(K_READY, 0, 32'd0, 32'd0);
      end
    end
    // push to full channel must be ignored
    valid_in = 1'b1;
    ch_in    = 2'd0;
    data_in  = 32'hDEAD_BEEF;
    step();
    valid_in = 1'b0;
    chk(K_FILL, 0, 32'd128, 32'd0);
    chk(K_AFULL, 0, 32'd1, 32'd0);
    step();
    drain(400);
    chk(K_FILL, 0, 32'd0, 32'd0);
    chk(K_READY, 0, 32'd1, 32'd0);
    step();

    // Round-robin across channels
    ready_in = 1'b0;
    for (int j = 0; j < 3; j++)
      for (int c = 0; c < 4; c++)
        push(CW'(c), 32'h2000_0000 + 32'(c << 8) + 32'(j));
    step();
    drain(100);

    // Latency and throughput on channel 1
    ready_in = 1'b1;
    first    = -1;
    bub      = 0;
    for (int k = 0; k < 506; k++) begin
      if (k < 500) begin
        valid_in = 1'b1;
        ch_in    = 2'd1;
        data_in  = 32'h3000_0000 + 32'(k);
        exp_q.push_back('{2'd1, 32'h3000_0000 + 32'(k)});
      end else begin
        valid_in = 1'b0;
      end
      step();
      if (valid_out) begin
        if (first < 0) first = k;
      end else if (first >= 0 && k < first + 500) begin
        bub++;
      end
    end
    valid_in = 1'b0;
    chk(K_GEN, G_LAT, 32'd2, 32'(first));
    chk(K_GEN, G_BUB, 32'd0, 32'(bub));
    drain(20);

    // Backpressure on channel 2
    ready_in = 1'b0;
    for (int i = 0; i < 10; i++) push(2'd2, 32'h4000_0000 + 32'(i));
    chk(K_FILL, 2, 32'd8, 32'd0);
    for (int n = 0; n < 20; n++) begin
      chk(K_VALID, 0, 32'd1, 32'd0);
      chk(K_DATA, 0, 32'h4000_0000, 32'd0);
      step();
    end
    chk(K_FILL, 2, 32'd8, 32'd0);
    drain(50);

    // Flush channel 2 with channel 0 queued behind it
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) push(2'd2, 32'h5000_0000 + 32'(i));
    for (int i = 0; i < 5; i++) push(2'd0, 32'h5000_0100 + 32'(i));
    flush_entries = 4'b0100;
    valid_in      = 1'b1;
    ch_in         = 2'd2;
    data_in       = 32'h5555_5555;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].ch == 2'd2) exp_q.delete(i);
    step();
    flush_entries = '0;
    valid_in      = 1'b0;
    chk(K_FILL, 2, 32'd0, 32'd0);
    chk(K_VALID, 0, 32'd0, 32'd0);
    chk(K_FILL, 0, 32'd5, 32'd0);
    step();
    drain(50);
    chk(K_FILL, 2, 32'd0, 32'd0);
    step();

    // Reset in the middle of traffic
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) push(2'd1, 32'h6000_0000 + 32'(i));
    rstn = 1'b0;
    step();
    exp_q.delete();
    rstn = 1'b1;
    reset_checks(1);
    step();

    // Parity: corrupt the stored parity bit of channel 3, word 2
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) push(2'd3, 32'h7000_0000 + 32'(i));
`ifdef AXI_BUFFER_RAB_BRAM_MC_PARITY_EN
    dut.mem[3*DEP+2][DW] = ~dut.mem[3*DEP+2][DW];
`endif
    chk(K_PERR, 0, 32'd0, 32'd0);
    step();
    drain(50);
    chk(K_PERR, 0, PERR_EXP, 32'd0);
    step();
    step();
    step();
    chk(K_PERR, 0, PERR_EXP, 32'd0);
    step();

    chk(K_GEN, G_DRAIN, 32'd0, 32'(exp_q.size()));
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
